// File: rtl/dac_config_scheduler.sv
// Queues host writes into a shadow bank and copies shadow -> live atomically in the idle wait state.
// Optional readback port of the live bank is enabled with `define DAC_CFG_READBACK_EN.
module dac_config_scheduler #(
  parameter logic [31:0] MS_WAIT    = 32'd99,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         dataclk,
  input  logic         reset,
  input  logic [31:0]  main_state,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [2:0]   wr_dac,
  input  logic [1:0]   wr_field,
  input  logic [15:0]  wr_data,
  input  logic         commit_req,
  output logic         commit_pending,
  output logic         update_applied,
  output logic [7:0]   DAC_en,
  output logic [23:0]  DAC_gain,
  output logic [55:0]  DAC_noise_suppress,
  output logic [127:0] DAC_thrsh,
  output logic [7:0]   DAC_thrsh_pol,
  output logic [15:0]  HPF_coefficient,
  output logic         HPF_en
`ifdef DAC_CFG_READBACK_EN
  ,
  input  logic [2:0]   rd_dac,
  input  logic [1:0]   rd_field,
  output logic [15:0]  rd_data
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [2:0]  dac;
    logic [1:0]  fld;
    logic [15:0] data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_ARMED} state_t;

  entry_t        fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] drain_cnt_q;
  state_t        state_q;
  logic          pending_q;
  logic          applied_q;

  logic          sh_en_q    [8];
  logic [2:0]    sh_gain_q  [8];
  logic [6:0]    sh_noise_q [8];
  logic [15:0]   sh_thr_q   [8];
  logic          sh_pol_q   [8];
  logic [15:0]   sh_coef_q;
  logic          sh_hpf_en_q;

  logic          lv_en_q    [8];
  logic [2:0]    lv_gain_q  [8];
  logic [6:0]    lv_noise_q [8];
  logic [15:0]   lv_thr_q   [8];
  logic          lv_pol_q   [8];
  logic [15:0]   lv_coef_q;
  logic          lv_hpf_en_q;

  logic   push, pop;
  entry_t fifo_head;

  assign wr_ready  = (count_q < CW'(FIFO_DEPTH));
  assign push      = wr_valid && wr_ready;
  assign fifo_head = fifo_mem_q[rd_ptr_q];

  // While draining, only entries counted at commit time may leave the queue.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      S_IDLE:  pop = (count_q != '0);
      S_DRAIN: pop = (drain_cnt_q != '0);
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge dataclk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {wr_dac, wr_field, wr_data};
  end

  always_ff @(posedge dataclk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q - CW'(pop) + CW'(push);
    end
  end

  always_ff @(posedge dataclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      pending_q   <= 1'b0;
      applied_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        sh_en_q[i]    <= 1'b0;
        sh_gain_q[i]  <= 3'd0;
        sh_noise_q[i] <= 7'd0;
        sh_thr_q[i]   <= 16'h8000;
        sh_pol_q[i]   <= 1'b0;
        lv_en_q[i]    <= 1'b0;
        lv_gain_q[i]  <= 3'd0;
        lv_noise_q[i] <= 7'd0;
        lv_thr_q[i]   <= 16'h8000;
        lv_pol_q[i]   <= 1'b0;
      end
      sh_coef_q   <= 16'd0;
      sh_hpf_en_q <= 1'b0;
      lv_coef_q   <= 16'd0;
      lv_hpf_en_q <= 1'b0;
    end else begin
      applied_q <= 1'b0;
      if (pop) begin
        case (fifo_head.fld)
          2'd0: begin
            sh_en_q[fifo_head.dac]    <= fifo_head.data[0];
            sh_gain_q[fifo_head.dac]  <= fifo_head.data[3:1];
            sh_noise_q[fifo_head.dac] <= fifo_head.data[10:4];
            sh_pol_q[fifo_head.dac]   <= fifo_head.data[11];
          end
          2'd1:    sh_thr_q[fifo_head.dac] <= fifo_head.data;
          2'd2:    sh_coef_q <= fifo_head.data;
          default: sh_hpf_en_q <= fifo_head.data[0];
        endcase
      end
      case (state_q)
        S_IDLE: begin
          if (commit_req) begin
            pending_q   <= 1'b1;
            state_q     <= S_DRAIN;
            // Same-cycle push belongs to this commit; same-cycle pop is already gone.
            drain_cnt_q <= count_q - CW'(pop) + CW'(push);
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q != '0)    drain_cnt_q <= drain_cnt_q - CW'(1);
          if (drain_cnt_q <= CW'(1)) state_q    <= S_ARMED;
        end
        S_ARMED: begin
          if (main_state == MS_WAIT) begin
            lv_en_q     <= sh_en_q;
            lv_gain_q   <= sh_gain_q;
            lv_noise_q  <= sh_noise_q;
            lv_thr_q    <= sh_thr_q;
            lv_pol_q    <= sh_pol_q;
            lv_coef_q   <= sh_coef_q;
            lv_hpf_en_q <= sh_hpf_en_q;
            applied_q   <= 1'b1;
            pending_q   <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_out
    assign DAC_en[gi]                  = lv_en_q[gi];
    assign DAC_gain[3*gi +: 3]         = lv_gain_q[gi];
    assign DAC_noise_suppress[7*gi +: 7] = lv_noise_q[gi];
    assign DAC_thrsh[16*gi +: 16]      = lv_thr_q[gi];
    assign DAC_thrsh_pol[gi]           = lv_pol_q[gi];
  end

  assign HPF_coefficient = lv_coef_q;
  assign HPF_en          = lv_hpf_en_q;
  assign commit_pending  = pending_q;
  assign update_applied  = applied_q;

`ifdef DAC_CFG_READBACK_EN
  logic [15:0] rd_data_q;

  always_ff @(posedge dataclk) begin
    if (reset) begin
      rd_data_q <= 16'd0;
    end else begin
      case (rd_field)
        2'd0:    rd_data_q <= {4'd0, lv_pol_q[rd_dac], lv_noise_q[rd_dac],
                               lv_gain_q[rd_dac], lv_en_q[rd_dac]};
        2'd1:    rd_data_q <= lv_thr_q[rd_dac];
        2'd2:    rd_data_q <= lv_coef_q;
        default: rd_data_q <= {15'd0, lv_hpf_en_q};
      endcase
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule
